// File: rtl/sample_interp_pkg.sv
// Shared audio DSP definitions for the sample interpolator: state encoding,
// default exponent range and the interp_sel clamp.
package sample_interp_pkg;

    localparam int unsigned SI_MAX_LOG2 = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    // Exponent selects above the supported maximum saturate to it.
    function automatic logic [2:0] clamp_sel(input logic [2:0] sel,
                                             input int unsigned max_log2);
        return (sel > 3'(max_log2)) ? 3'(max_log2) : sel;
    endfunction

endpackage

// File: rtl/sample_interp_if.sv
// Sample-in / interpolated-sample-out handshake bundle of the interpolator.
interface sample_interp_if #(
    parameter int unsigned BIT_WIDTH = 16
);
    logic [2:0]           interp_sel;
    logic [BIT_WIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output interp_sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  interp_sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/sample_interp.sv
// Linear-ramp upsampler: each accepted sample produces 2^k beats stepping
// from the previous sample to the new one.
module sample_interp
    import sample_interp_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned MAX_LOG2  = SI_MAX_LOG2
) (
    input  logic            clk,
    input  logic            clr_n,
    sample_interp_if.slave  bus
);

    localparam int unsigned DW = BIT_WIDTH + 1;
    localparam int unsigned AW = BIT_WIDTH + MAX_LOG2 + 1;
    localparam int unsigned CW = MAX_LOG2 + 1;

    state_t               state_q, state_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [DW-1:0]        diff_q, diff_d;
    logic [BIT_WIDTH-1:0] prev_q, prev_d;
    logic [BIT_WIDTH-1:0] x_q, x_d;
    logic [BIT_WIDTH-1:0] out_data_q, out_data_d;
    logic [2:0]           k_q, k_d;
    logic [CW-1:0]        beat_q, beat_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    // Sign-extend the (two's complement) step to accumulator width.
    function automatic logic [AW-1:0] sext(input logic [DW-1:0] d);
        return {{(AW-DW){d[DW-1]}}, d};
    endfunction

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            diff_q      <= '0;
            prev_q      <= '0;
            x_q         <= '0;
            out_data_q  <= '0;
            k_q         <= '0;
            beat_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            diff_q      <= diff_d;
            prev_q      <= prev_d;
            x_q         <= x_d;
            out_data_q  <= out_data_d;
            k_q         <= k_d;
            beat_q      <= beat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        diff_d  = diff_q;
        prev_d  = prev_q;
        x_d     = x_q;
        k_d     = k_q;
        beat_d  = beat_q;

        unique case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone accepts.
                if (bus.in_valid) begin
                    k_d     = clamp_sel(bus.interp_sel, MAX_LOG2);
                    x_d     = bus.in_data;
                    diff_d  = DW'(bus.in_data) - DW'(prev_q);
                    acc_d   = (AW'(prev_q) << k_d) + sext(diff_d);
                    beat_d  = CW'(1);
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (bus.out_ready) begin
                    if (beat_q == (CW'(1) << k_q)) begin
                        prev_d  = x_q;
                        state_d = IDLE;
                    end else begin
                        acc_d  = acc_q + sext(diff_q);
                        beat_d = beat_q + CW'(1);
                    end
                end
            end
        endcase

        out_data_d  = BIT_WIDTH'(acc_d >> k_d);
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == RAMP);
    end

endmodule

// File: tb/tb_sample_interp.sv
// Directed bench for sample_interp: a beat-list model predicts every ramp,
// checked each cycle, plus hand-computed sequences for the named scenarios.
module tb_sample_interp;
    import sample_interp_pkg::*;

    localparam int unsigned BW = 16;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    sample_interp_if #(.BIT_WIDTH(BW)) bus ();

    sample_interp #(.BIT_WIDTH(BW), .MAX_LOG2(4)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int exp_q[$];
    int got[$];
    int got_cyc[$];
    int m_prev  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: on accept, list the 2^k beats floor((prev*2^k + i*(x-prev)) / 2^k).
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            exp_q.delete();
            m_prev = 0;
        end else begin
            cyc++;
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                got.push_back(int'(bus.out_data));
                got_cyc.push_back(cyc);
                void'(exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                int k, n, x;
                k = (int'(bus.interp_sel) > 4) ? 4 : int'(bus.interp_sel);
                n = 1 << k;
                x = int'(bus.in_data);
                for (int i = 1; i <= n; i++)
                    exp_q.push_back((m_prev * n + i * (x - m_prev)) / n);
                m_prev  = x;
                acc_cyc = cyc;
            end
        end
    end

    // Outputs are meaningful on every cycle out of reset.
    always @(negedge clk) begin
        if (clr_n) begin
            chk("out_valid", bus.out_valid, exp_q.size() != 0);
            chk("in_ready", bus.in_ready, exp_q.size() == 0);
            if (exp_q.size() != 0 && bus.out_valid)
                chk("out_data", bus.out_data, exp_q[0]);
        end
    end

    task automatic send(input int x, input int sel);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.in_data    = BW'(x);
        bus.interp_sel = 3'(sel);
        bus.in_valid   = 1'b1;
        @(negedge clk);
        bus.in_valid   = 1'b0;
    endtask

    task automatic wait_done(input bit stall);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 500) begin
            bus.out_ready = stall ? (n % 3 == 0) : 1'b1;
            @(negedge clk);
            n++;
        end
        bus.out_ready = 1'b1;
        if (n >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: ramp still active after %0d cycles", n);
        end
    endtask

    task automatic expect_seq(input string nm, input int exp[]);
        chk({nm, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(nm, got[i], exp[i]);
    endtask

    task automatic clear_log();
        got.delete();
        got_cyc.delete();
    endtask

    initial begin
        int n;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.interp_sel = '0;
        bus.out_ready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        @(posedge clk);
        #2 clr_n = 1'b1;

        // k=2, 0 -> 100, beats on consecutive cycles right after accept
        clear_log();
        send(100, 2);
        wait_done(1'b0);
        expect_seq("k2_ramp", '{25, 50, 75, 100});
        if (got_cyc.size() == 4) begin
            chk("k2_latency", got_cyc[0], acc_cyc + 1);
            chk("k2_back2back", got_cyc[3], got_cyc[0] + 3);
        end

        // k=1, 100 -> 0
        clear_log();
        send(0, 1);
        wait_done(1'b0);
        expect_seq("k1_down", '{50, 0});

        // k=4 full-scale up, then back down
        clear_log();
        send(65535, 4);
        wait_done(1'b0);
        chk("fs_up_count", got.size(), 16);
        if (got.size() == 16) begin
            chk("fs_up_first", got[0], 4095);
            chk("fs_up_last", got[15], 65535);
            for (int i = 1; i < 16; i++)
                chk("fs_up_monotonic", got[i] > got[i-1], 1);
        end
        clear_log();
        send(0, 4);
        wait_done(1'b0);
        chk("fs_dn_count", got.size(), 16);
        if (got.size() == 16) begin
            chk("fs_dn_first", got[0], 61439);
            chk("fs_dn_last", got[15], 0);
            for (int i = 1; i < 16; i++)
                chk("fs_dn_monotonic", got[i] < got[i-1], 1);
        end

        // k=2 with out_ready pattern 1,0,0: beats held, three cycles apart
        clear_log();
        send(200, 2);
        wait_done(1'b1);
        expect_seq("stall_ramp", '{50, 100, 150, 200});
        if (got_cyc.size() == 4)
            chk("stall_spacing", got_cyc[3] - got_cyc[0], 9);

        // interp_sel=7 saturates to factor 16: 200 -> 40 in steps of 10
        clear_log();
        send(40, 7);
        wait_done(1'b0);
        chk("sel7_count", got.size(), 16);
        if (got.size() == 16) begin
            chk("sel7_first", got[0], 190);
            chk("sel7_last", got[15], 40);
        end

        // x == prev with interp_sel moved 2 -> 0 mid-ramp
        clear_log();
        send(40, 2);
        bus.interp_sel = 3'd0;
        wait_done(1'b0);
        expect_seq("const_midsel", '{40, 40, 40, 40});

        // reset after beat 2 of a k=3 ramp 40 -> 120
        clear_log();
        send(120, 3);
        n = 0;
        while (got.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_beats", got.size(), 2);
        clr_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_data", bus.out_data, 0);
        @(posedge clk);
        #2 clr_n = 1'b1;
        repeat (4) @(negedge clk);
        expect_seq("pre_rst_ramp", '{50, 60});

        // after reset prev is 0: k=0, in 40 -> single beat 40
        clear_log();
        send(40, 0);
        wait_done(1'b0);
        expect_seq("k0_after_rst", '{40});

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sample_interp.md
SAMPLE_INTERP -- requirements
Module: sample_interp

Interface
REQ-001 Parameter BIT_WIDTH, default 16: sample width, unsigned.
REQ-002 Parameter MAX_LOG2, default 4: largest interpolation exponent (factor 16).
REQ-003 clk  in  1: sole clock; all state changes on its rising edge.
REQ-004 clr_n  in  1: reset, asynchronous, active-low.
REQ-005 interp_sel  in  3: interpolation exponent k; 0..4 gives factor 2^k; 5..7 behave as 4.
REQ-006 in_data  in  BIT_WIDTH: new target sample.
REQ-007 in_valid  in  1: in_data valid.
REQ-008 in_ready  out  1: block accepts a sample this cycle.
REQ-009 out_data  out  BIT_WIDTH: interpolated sample.
REQ-010 out_valid  out  1: out_data valid.
REQ-011 out_ready  in  1: downstream consumes out_data this cycle.

Function
REQ-012 The block SHALL upsample by 2^k, emitting a linear ramp from the previous sample (prev) to each new sample (x).
REQ-013 An input is accepted when in_valid and in_ready are both high on a rising edge.
REQ-014 Two states: IDLE (in_ready=1, out_valid=0) and RAMP (in_ready=0, out_valid=1).
REQ-015 IDLE->RAMP on accept; on the accept edge k is latched from interp_sel, diff = x - prev is formed signed at BIT_WIDTH+1 bits, and the accumulator is loaded with prev*2^k + diff.
REQ-016 out_valid SHALL rise in the cycle after accept (latency 1).
REQ-017 out_data SHALL equal acc >> k; beat i (1..2^k) equals floor((prev*2^k + i*diff) / 2^k).
REQ-018 The accumulator SHALL be BIT_WIDTH+MAX_LOG2+1 bits; it SHALL never overflow or go negative.
REQ-019 A beat is consumed when out_valid and out_ready are both high; the accumulator then adds diff and the beat counter increments.
REQ-020 While out_ready is low, out_data and out_valid SHALL hold unchanged.
REQ-021 Beat 2^k SHALL equal x exactly; on its consumption prev<=x and the state returns to IDLE; in_ready is high the following cycle.
REQ-022 k=0 SHALL produce exactly one beat equal to x.
REQ-023 interp_sel changes during RAMP SHALL be ignored until the next accept.
REQ-024 x equal to prev SHALL produce 2^k beats of constant value x.
REQ-025 Full-scale swings (0 to 2^BIT_WIDTH-1 and back) SHALL ramp correctly without wrap-around.

Reset
REQ-026 Asserting clr_n low at any time, including mid-ramp, SHALL force: state IDLE, prev=0, accumulator=0, beat counter=0, k=0, out_data=0, out_valid=0, in_ready=1 after release.
REQ-027 An in-progress ramp SHALL be discarded on reset; no partial beats are emitted after release.

Structure
REQ-028 State encoding (IDLE/RAMP), MAX_LOG2 and the clamp table for interp_sel SHALL live in the shared audio DSP package.
REQ-029 No sub-module is required; the optional sub-module sample_interp_acc (accumulator plus shift) may be used.

Verification
REQ-030 Test k=2, prev=0, in 100, out_ready=1 -> out 25,50,75,100 on 4 consecutive cycles starting 1 cycle after accept; then in_ready=1.
REQ-031 Test k=1, prev=100, in 0 -> out 50,0; prev becomes 0.
REQ-032 Test k=4, prev=0, in 0xFFFF -> 16 beats, last 0xFFFF, monotonic, no wrap; then in 0 -> descending to 0.
REQ-033 Test k=2, out_ready toggling 1,0,0,1... -> each beat held while stalled, sequence unchanged; in_ready stays 0 until the final beat is consumed.
REQ-034 Test interp_sel=7 -> identical to k=4; interp_sel changed 2->0 mid-ramp -> current ramp still emits 4 beats.
REQ-035 Test clr_n low after beat 2 of a k=3 ramp -> out_valid=0 and out_data=0 immediately; after release in 40 with k=0 -> single beat 40.
